// File: rtl/dma_r_sched_if.sv
// Downstream request/data channel between the read scheduler and the axi_dma_r engine.
// The scheduler is the master: it presents valid/addr/len and receives rdata/ready.
interface dma_r_sched_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256,
  parameter int LEN_W  = 8
);
  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (output valid, addr, len, input rdata, ready);
  modport slave  (input valid, addr, len, output rdata, ready);
endinterface

// File: rtl/dma_r_sched.sv
// Burst-locking round-robin scheduler sharing one AXI DMA read engine between N_REQ requesters.
// Tracks remaining beats per requester per frame and sizes each AXI burst from that count.
module dma_r_sched #(
  parameter  int N_REQ  = 2,
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 256,
  parameter  int CNT_W  = 16,
  parameter  int LEN_W  = 8,
  localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    run,
  input  logic [N_REQ*CNT_W-1:0]  cfg_len,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ*DATA_W-1:0] req_rdata,
  output logic [N_REQ-1:0]        req_ready,
  dma_r_sched_if.master           s,
  output logic                    busy,
  output logic [ID_W-1:0]         grant_id
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state, state_next;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   grant_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat;
  logic [CNT_W-1:0]  cnt    [N_REQ];
  logic [CNT_W-1:0]  shadow [N_REQ];

  logic              found;
  logic [ID_W-1:0]   pick;
  logic [ID_W-1:0]   cand;
  int                scan_idx;
  logic              last_beat;

  // Counts above the AXI maximum saturate to a full-length burst.
  function automatic logic [LEN_W-1:0] burst_len(input logic [CNT_W-1:0] c);
    return (|c[CNT_W-1:LEN_W]) ? {LEN_W{1'b1}} : c[LEN_W-1:0];
  endfunction

  always_comb begin
    found    = 1'b0;
    pick     = '0;
    cand     = '0;
    scan_idx = 0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = int'(ptr) + k;
      if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
      cand = ID_W'(scan_idx);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign last_beat = (state == BURST) && s.ready && (beat == len_q);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = BURST;
      BURST:   if (last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s.valid   = 1'b0;
    s.addr    = '0;
    req_ready = '0;
    if (state == BURST) begin
      s.valid            = req_valid[grant_q];
      s.addr             = req_addr[int'(grant_q)*ADDR_W +: ADDR_W];
      req_ready[grant_q] = s.ready;
    end
  end

  assign s.len     = len_q;
  assign busy      = (state == BURST);
  assign grant_id  = grant_q;
  assign req_rdata = {N_REQ{s.rdata}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ptr     <= '0;
      grant_q <= '0;
      len_q   <= '0;
      beat    <= '0;
    end else if (clear) begin
      state <= IDLE;
      ptr   <= '0;
      beat  <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        if (found) begin
          grant_q <= pick;
          len_q   <= burst_len(cnt[pick]);
          beat    <= '0;
        end
      end else if (s.ready) begin
        if (beat == len_q) begin
          beat <= '0;
          ptr  <= (grant_q == ID_W'(N_REQ-1)) ? '0 : grant_q + 1'b1;
        end else begin
          beat <= beat + 1'b1;
        end
      end
    end
  end

  // A beat on a zero count wraps the frame by reloading the shadow; run beats a same-cycle beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt[i]    <= '0;
        shadow[i] <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
    end else if (run) begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt[i]    <= cfg_len[i*CNT_W +: CNT_W];
        shadow[i] <= cfg_len[i*CNT_W +: CNT_W];
      end
    end else if ((state == BURST) && s.ready) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant_q == ID_W'(i)) begin
          cnt[i] <= (cnt[i] == '0) ? shadow[i] : cnt[i] - 1'b1;
        end
      end
    end
  end

endmodule
